// File: rtl/arc4_encrypt.sv
// ARC4 encryptor.
// Builds the RC4 state in an external 256x8 S memory (INIT, then KSA), then runs
// the PRGA over a length-prefixed plaintext buffer and writes the length-prefixed
// ciphertext buffer. All memories are synchronous-read with one cycle of latency:
// an address registered on edge N is sampled by the memory on edge N+1, and the
// data it returns is captured here on edge N+2.
module arc4_encrypt #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  output logic [7:0]             pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [7:0]             ct_addr,
  output logic [7:0]             ct_wrdata,
  output logic                   ct_wren
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    ST_K_RD_SI,
    ST_K_WT_SI,
    ST_K_RD_SJ,
    ST_K_WT_SJ,
    ST_K_WR_SI,
    ST_K_WR_SJ,
    ST_P_RD_L,
    ST_P_WT_L,
    ST_P_CAP_L,
    ST_P_RD_SI,
    ST_P_WT_SI,
    ST_P_RD_SJ,
    ST_P_WT_SJ,
    ST_P_WR_SI,
    ST_P_WR_SJ,
    ST_P_RD_PAD,
    ST_P_WT_PAD,
    ST_P_WR_CT,
    ST_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_rdy;
  logic [7:0]             r_s_addr;
  logic [7:0]             r_s_wrdata;
  logic                   r_s_wren;
  logic [7:0]             r_pt_addr;
  logic [7:0]             r_ct_addr;
  logic [7:0]             r_ct_wrdata;
  logic                   r_ct_wren;
  logic [8*KEY_BYTES-1:0] r_key;
  logic [KIDX_W-1:0]      r_kidx;   // i mod KEY_BYTES, kept as a wrapping counter
  logic [7:0]             r_i;      // doubles as the fill counter during INIT
  logic [7:0]             r_j;
  logic [7:0]             r_k;      // index of the last ciphertext byte written
  logic [7:0]             r_len;    // message length L from pt[0]
  logic [7:0]             r_si;     // s[i] as read before the swap
  logic [7:0]             r_sj;     // s[j] as read before the swap
  logic [7:0]             r_pt;     // plaintext byte for the current k

  logic [7:0]             w_keybyte;
  logic [7:0]             w_i_next;
  logic [7:0]             w_k_next;
  logic [7:0]             w_j_ksa;
  logic [7:0]             w_j_prga;
  logic [7:0]             w_pad_addr;

  // Select key byte r_kidx; byte 0 is the most significant byte of the key.
  always_comb begin
    w_keybyte = 8'd0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      w_keybyte = (r_kidx == KIDX_W'(n)) ? r_key[8*(KEY_BYTES-n)-1 -: 8] : w_keybyte;
    end
  end

  // Index arithmetic; every sum wraps mod 256 by construction of the 8-bit width.
  always_comb begin
    w_i_next   = r_i + 8'd1;
    w_k_next   = r_k + 8'd1;
    w_j_ksa    = r_j + s_rddata + w_keybyte;
    w_j_prga   = r_j + s_rddata;
    // After the swap s[i]=old s[j] and s[j]=old s[i]; the sum is the same either way.
    w_pad_addr = r_si + r_sj;
  end

  // Main controller: sequences INIT, KSA and PRGA and drives all memory ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rdy       <= 1'b1;
      r_s_addr    <= 8'd0;
      r_s_wrdata  <= 8'd0;
      r_s_wren    <= 1'b0;
      r_pt_addr   <= 8'd0;
      r_ct_addr   <= 8'd0;
      r_ct_wrdata <= 8'd0;
      r_ct_wren   <= 1'b0;
      r_key       <= '0;
      r_kidx      <= '0;
      r_i         <= 8'd0;
      r_j         <= 8'd0;
      r_k         <= 8'd0;
      r_len       <= 8'd0;
      r_si        <= 8'd0;
      r_sj        <= 8'd0;
      r_pt        <= 8'd0;
    end else begin
      // Write strobes are single-cycle pulses unless a state re-asserts them.
      r_s_wren  <= 1'b0;
      r_ct_wren <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_key   <= key;
            r_rdy   <= 1'b0;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_k     <= 8'd0;
            r_kidx  <= '0;
            r_state <= ST_INIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        // s[k] = k, one write per cycle.
        ST_INIT: begin
          r_s_addr   <= r_i;
          r_s_wrdata <= r_i;
          r_s_wren   <= 1'b1;
          r_i        <= w_i_next;
          if (r_i == 8'd255) begin
            r_state <= ST_K_RD_SI;
          end else begin
            r_state <= ST_INIT;
          end
        end

        ST_K_RD_SI: begin
          r_s_addr <= r_i;
          r_state  <= ST_K_WT_SI;
        end

        ST_K_WT_SI: begin
          r_state <= ST_K_RD_SJ;
        end

        ST_K_RD_SJ: begin
          r_si     <= s_rddata;
          r_j      <= w_j_ksa;
          r_s_addr <= w_j_ksa;
          r_state  <= ST_K_WT_SJ;
        end

        ST_K_WT_SJ: begin
          r_state <= ST_K_WR_SI;
        end

        ST_K_WR_SI: begin
          r_sj       <= s_rddata;
          r_s_addr   <= r_i;
          r_s_wrdata <= s_rddata;
          r_s_wren   <= 1'b1;
          r_state    <= ST_K_WR_SJ;
        end

        // When i==j this rewrites the same location with the same value.
        ST_K_WR_SJ: begin
          r_s_addr   <= r_j;
          r_s_wrdata <= r_si;
          r_s_wren   <= 1'b1;
          if (r_kidx == KIDX_W'(KEY_BYTES - 1)) begin
            r_kidx <= '0;
          end else begin
            r_kidx <= r_kidx + KIDX_W'(1);
          end
          if (r_i == 8'd255) begin
            r_state <= ST_P_RD_L;
          end else begin
            r_i     <= w_i_next;
            r_state <= ST_K_RD_SI;
          end
        end

        ST_P_RD_L: begin
          r_pt_addr <= 8'd0;
          r_state   <= ST_P_WT_L;
        end

        ST_P_WT_L: begin
          r_state <= ST_P_CAP_L;
        end

        // ct[0] = L, then the keystream starts over from i=j=0.
        ST_P_CAP_L: begin
          r_len       <= pt_rddata;
          r_ct_addr   <= 8'd0;
          r_ct_wrdata <= pt_rddata;
          r_ct_wren   <= 1'b1;
          r_i         <= 8'd0;
          r_j         <= 8'd0;
          r_k         <= 8'd0;
          if (pt_rddata == 8'd0) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_P_RD_SI;
          end
        end

        // The plaintext read for this byte is issued alongside the s[i] read.
        ST_P_RD_SI: begin
          r_i       <= w_i_next;
          r_s_addr  <= w_i_next;
          r_pt_addr <= w_k_next;
          r_state   <= ST_P_WT_SI;
        end

        ST_P_WT_SI: begin
          r_state <= ST_P_RD_SJ;
        end

        ST_P_RD_SJ: begin
          r_si     <= s_rddata;
          r_pt     <= pt_rddata;
          r_j      <= w_j_prga;
          r_s_addr <= w_j_prga;
          r_state  <= ST_P_WT_SJ;
        end

        ST_P_WT_SJ: begin
          r_state <= ST_P_WR_SI;
        end

        ST_P_WR_SI: begin
          r_sj       <= s_rddata;
          r_s_addr   <= r_i;
          r_s_wrdata <= s_rddata;
          r_s_wren   <= 1'b1;
          r_state    <= ST_P_WR_SJ;
        end

        ST_P_WR_SJ: begin
          r_s_addr   <= r_j;
          r_s_wrdata <= r_si;
          r_s_wren   <= 1'b1;
          r_state    <= ST_P_RD_PAD;
        end

        // The s[j] write lands on this edge, before the pad address is sampled.
        ST_P_RD_PAD: begin
          r_s_addr <= w_pad_addr;
          r_state  <= ST_P_WT_PAD;
        end

        ST_P_WT_PAD: begin
          r_state <= ST_P_WR_CT;
        end

        ST_P_WR_CT: begin
          r_ct_addr   <= w_k_next;
          r_ct_wrdata <= r_pt ^ s_rddata;
          r_ct_wren   <= 1'b1;
          r_k         <= w_k_next;
          if (w_k_next == r_len) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_P_RD_SI;
          end
        end

        // The final ct write was issued on the previous edge.
        ST_DONE: begin
          r_rdy   <= 1'b1;
          r_state <= ST_IDLE;
        end

        default: begin
          r_rdy   <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdy       = r_rdy;
  assign s_addr    = r_s_addr;
  assign s_wrdata  = r_s_wrdata;
  assign s_wren    = r_s_wren;
  assign pt_addr   = r_pt_addr;
  assign ct_addr   = r_ct_addr;
  assign ct_wrdata = r_ct_wrdata;
  assign ct_wren   = r_ct_wren;

endmodule

// File: tb/tb_arc4_encrypt.sv
// Testbench for arc4_encrypt: synchronous S/PT/CT memory models, a software RC4
// reference feeding an expected-write queue, and per-scenario test tasks.
module tb_arc4_encrypt;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  s_addr;
  logic [7:0]  s_rddata;
  logic [7:0]  s_wrdata;
  logic        s_wren;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_wrdata;
  logic        ct_wren;

  arc4_encrypt #(.KEY_BYTES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];

  // Synchronous memories, one cycle read latency.
  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          run_cycles;
  bit          run_timeout;
  int          idle_writes;
  int          ct_wr_count;
  int          max_ct_addr;
  int          addr0_writes;
  logic        rdy_after_accept;
  logic [7:0]  golden1 [10];
  logic [7:0]  plain1  [10];

  // Software RC4 reference over the current pt_mem; fills exp_q with {addr,data}.
  task automatic model_encrypt(input logic [23:0] k);
    logic [7:0] sm [256];
    logic [7:0] kb [3];
    logic [7:0] i, j, t, len, pad;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    exp_q.delete();
    for (int n = 0; n < 256; n++) sm[n] = 8'(n);
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      j = j + sm[n] + kb[n % 3];
      t = sm[n]; sm[n] = sm[j]; sm[j] = t;
    end
    len = pt_mem[0];
    exp_q.push_back({8'd0, len});
    i = 8'd0;
    j = 8'd0;
    for (int n = 1; n <= int'(len); n++) begin
      i = i + 8'd1;
      j = j + sm[i];
      t = sm[i]; sm[i] = sm[j]; sm[j] = t;
      t = sm[i] + sm[j];
      pad = sm[t];
      exp_q.push_back({8'(n), pt_mem[n] ^ pad});
    end
  endtask

  task automatic load_pt1();
    for (int n = 0; n < 256; n++) pt_mem[n] = 8'd0;
    pt_mem[0] = 8'd9;
    for (int n = 1; n < 10; n++) pt_mem[n] = plain1[n];
  endtask

  task automatic start_run(input logic [23:0] k);
    @(negedge clk);
    en  = 1'b1;
    key = k;
    @(negedge clk);
    en = 1'b0;
    rdy_after_accept = rdy;
  endtask

  // Advance until rdy returns (bounded), recording every ct write observed.
  task automatic run_to_ready(input int budget, input bit pulse, input logic [23:0] alt_key);
    bit done;
    done = 1'b0;
    obs_q.delete();
    ct_wr_count = 0; max_ct_addr = -1; addr0_writes = 0; idle_writes = 0; run_cycles = 1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      run_cycles++;
      if (ct_wren) begin
        obs_q.push_back({ct_addr, ct_wrdata});
        ct_wr_count++;
        if (int'(ct_addr) > max_ct_addr) max_ct_addr = int'(ct_addr);
        if (ct_addr == 8'd0) addr0_writes++;
      end
      if (rdy && (s_wren || ct_wren)) idle_writes++;
      if (rdy) begin
        done = 1'b1;
        break;
      end
      if (pulse && ct_wr_count > 0) begin
        en  = (c % 3 == 0);
        key = alt_key;
      end
    end
    en = 1'b0;
    run_timeout = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; key = 24'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rdy, s_wren, ct_wren} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy/s_wren/ct_wren=%b expected 100", {rdy, s_wren, ct_wren});
    end
    checks++;
    if ({s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata} !== 40'd0) begin
      failures++;
      $display("FAIL reset_bus: got %h expected 0", {s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_key_vector(input string tag, input bit pulse);
    load_pt1();
    model_encrypt(24'h4B6579);
    start_run(24'h4B6579);
    checks++;
    if (rdy_after_accept !== 1'b0) begin
      failures++;
      $display("FAIL %s_rdy_drop: got %b expected 0", tag, rdy_after_accept);
    end
    run_to_ready(6000, pulse, 24'h123456);
    checks++;
    if (run_timeout) begin
      failures++;
      $display("FAIL %s_timeout: got no rdy expected rdy within 6000 cycles", tag);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d writes expected %0d", tag, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s_sb: got addr/data %h expected %h", tag, o, e);
      end
    end
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (ct_mem[n] !== golden1[n]) begin
        failures++;
        $display("FAIL %s_golden[%0d]: got %h expected %h", tag, n, ct_mem[n], golden1[n]);
      end
    end
    checks++;
    if (idle_writes != 0 || run_cycles > 256 + 2048 + 4 + 9 * 12) begin
      failures++;
      $display("FAIL %s_disc: got idle_writes=%0d cycles=%0d expected 0 and <=%0d",
               tag, idle_writes, run_cycles, 256 + 2048 + 4 + 108);
    end
  endtask

  task automatic test_round_trip();
    for (int n = 0; n < 10; n++) pt_mem[n] = ct_mem[n];
    model_encrypt(24'h4B6579);
    start_run(24'h4B6579);
    run_to_ready(6000, 1'b0, 24'd0);
    checks++;
    if (run_timeout || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rt_run: got timeout=%0d writes=%0d expected 0 and %0d",
               run_timeout, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rt_sb: got %h expected %h", o, e);
      end
    end
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (ct_mem[n] !== plain1[n]) begin
        failures++;
        $display("FAIL rt_plain[%0d]: got %h expected %h", n, ct_mem[n], plain1[n]);
      end
    end
  endtask

  task automatic test_len_zero();
    pt_mem[0] = 8'd0;
    start_run(24'hABCDEF);
    run_to_ready(6000, 1'b0, 24'd0);
    checks++;
    if (run_timeout || run_cycles > 256 + 2048 + 4) begin
      failures++;
      $display("FAIL l0_latency: got timeout=%0d cycles=%0d expected <=2308", run_timeout, run_cycles);
    end
    checks++;
    if (ct_wr_count != 1 || obs_q.size() != 1) begin
      failures++;
      $display("FAIL l0_count: got %0d writes expected 1", ct_wr_count);
    end else begin
      checks++;
      if (obs_q[0] !== 16'h0000) begin
        failures++;
        $display("FAIL l0_data: got %h expected 0000", obs_q[0]);
      end
    end
  endtask

  task automatic test_len_max();
    for (int n = 0; n < 256; n++) pt_mem[n] = 8'd0;
    pt_mem[0] = 8'd255;
    model_encrypt(24'h000018);
    start_run(24'h000018);
    run_to_ready(8000, 1'b0, 24'd0);
    checks++;
    if (run_timeout || run_cycles > 256 + 2048 + 4 + 255 * 12) begin
      failures++;
      $display("FAIL lmax_latency: got timeout=%0d cycles=%0d expected <=%0d",
               run_timeout, run_cycles, 256 + 2048 + 4 + 255 * 12);
    end
    checks++;
    if (ct_wr_count != 256 || max_ct_addr != 255 || addr0_writes != 1) begin
      failures++;
      $display("FAIL lmax_shape: got writes=%0d max=%0d addr0=%0d expected 256 255 1",
               ct_wr_count, max_ct_addr, addr0_writes);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL lmax_sb: got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid_ksa();
    load_pt1();
    start_run(24'h4B6579);
    repeat (400) @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL ksa_busy: got rdy=%b expected 0", rdy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy, s_wren, ct_wren, s_addr} !== {3'b100, 8'd0}) begin
      failures++;
      $display("FAIL ksa_reset: got %h expected %h", {rdy, s_wren, ct_wren, s_addr}, {3'b100, 8'd0});
    end
    rst = 1'b0;
    test_key_vector("after_rst", 1'b0);
  endtask

  task automatic test_back_to_back();
    bit seen;
    pt_mem[0] = 8'd0;
    @(negedge clk);
    en = 1'b1; key = 24'h010203;
    @(negedge clk);
    seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (rdy) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL b2b_first: got no rdy expected rdy within 4000 cycles");
    end
    @(negedge clk);
    en = 1'b0;
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: got rdy=%b expected 0", rdy);
    end
    run_to_ready(4000, 1'b0, 24'd0);
    checks++;
    if (run_timeout || ct_wr_count != 1) begin
      failures++;
      $display("FAIL b2b_second: got timeout=%0d writes=%0d expected 0 and 1", run_timeout, ct_wr_count);
    end
  endtask

  initial begin
    golden1 = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    plain1  = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int n = 0; n < 256; n++) begin
      pt_mem[n] = 8'd0;
      ct_mem[n] = 8'd0;
      s_mem[n]  = 8'd0;
    end
    test_reset();
    test_key_vector("kv", 1'b0);
    test_round_trip();
    test_len_zero();
    test_len_max();
    test_reset_mid_ksa();
    test_key_vector("en_ign", 1'b1);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
